// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller: memory wait, branch flush, load-use stall (optional stall counter: HAZ_PERF_CNT_EN)
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        exmem_branch,
    input  logic        exmem_zero,
    input  logic        exmem_memread,
    input  logic        exmem_memwrite,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt
);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_wait_cnt;
    logic       r_mem_timeout;
    logic       w_memop;
    logic       w_memstall;
    logic       w_branch_flush;
    logic       w_load_use;
    logic       w_freeze;

    // Hazard detection terms from the EX/MEM and ID/EX stage contents
    always_comb begin
        w_memop        = exmem_memread | exmem_memwrite;
        w_memstall     = w_memop & ~dmem_ready;
        w_branch_flush = exmem_branch & exmem_zero;
        w_load_use     = idex_memread & (idex_rt != 5'd0) &
                         ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));
    end

    // State register; reset abandons any memory wait in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and stage enables/flushes, priority memstall > branch > load-use
    always_comb begin
        w_next_state = r_state;
        w_freeze     = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;
        case (r_state)
            RUN: begin
                w_freeze = w_memstall;
                if (w_memstall) begin
                    w_next_state = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // Once waiting, only the memory's ready releases the pipeline
                w_freeze = ~dmem_ready;
                if (dmem_ready) begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RUN;
            end
        endcase
        if (w_freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (w_branch_flush) begin
            // ID is squashed, so a load-use against it is moot
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    // Wait counter: cleared on entry to MEM_WAIT, counts cycles spent there
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == RUN && w_next_state == MEM_WAIT) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == MEM_WAIT && r_wait_cnt != 8'hFF) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Sticky timeout once a wait has lasted 256 cycles; the FSM keeps waiting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_timeout <= 1'b0;
        end else if (r_state == MEM_WAIT && r_wait_cnt == 8'hFF) begin
            r_mem_timeout <= 1'b1;
        end
    end

    assign mem_timeout = r_mem_timeout;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles in which the PC is held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 16'd0;
        end else if (!pc_en && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        exmem_branch;
    logic        exmem_zero;
    logic        exmem_memread;
    logic        exmem_memwrite;
    logic        dmem_ready;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;
    logic        memwb_flush;
    logic        mem_timeout;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush}
    localparam logic [8:0] C_NONE   = 9'b11111_0000;
    localparam logic [8:0] C_FREEZE = 9'b00000_0001;
    localparam logic [8:0] C_BRANCH = 9'b11111_1110;
    localparam logic [8:0] C_LDUSE  = 9'b00111_0100;

    wire [8:0] ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush, memwb_flush};

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .idex_memread   (idex_memread),
        .idex_rt        (idex_rt),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .exmem_branch   (exmem_branch),
        .exmem_zero     (exmem_zero),
        .exmem_memread  (exmem_memread),
        .exmem_memwrite (exmem_memwrite),
        .dmem_ready     (dmem_ready),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_flush    (exmem_flush),
        .memwb_flush    (memwb_flush),
        .mem_timeout    (mem_timeout),
        .stall_cnt      (stall_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input logic lmr, input logic [4:0] lrt, input logic [4:0] rs,
                          input logic [4:0] rt, input logic br, input logic zr,
                          input logic mr, input logic mw, input logic rdy);
        idex_memread   = lmr;
        idex_rt        = lrt;
        ifid_rs        = rs;
        ifid_rt        = rt;
        exmem_branch   = br;
        exmem_zero     = zr;
        exmem_memread  = mr;
        exmem_memwrite = mw;
        dmem_ready     = rdy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #5;
        chk("reset_ctl", {7'd0, ctl}, {7'd0, C_NONE});
        chk("reset_timeout", {15'd0, mem_timeout}, 16'd0);
        chk("reset_stall_cnt", stall_cnt, 16'd0);
        tick(2);
        rst = 1'b1;
        tick(1);

        set_in(0, 5, 5, 0, 0, 0, 0, 0, 1); #1;
        chk("no_load_same_reg", {7'd0, ctl}, {7'd0, C_NONE});
        set_in(1, 5, 5, 0, 0, 0, 0, 0, 1); #1;
        chk("load_use_rs", {7'd0, ctl}, {7'd0, C_LDUSE});
        set_in(1, 7, 3, 7, 0, 0, 0, 0, 1); #1;
        chk("load_use_rt", {7'd0, ctl}, {7'd0, C_LDUSE});
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("load_use_r0", {7'd0, ctl}, {7'd0, C_NONE});
        set_in(1, 9, 8, 10, 0, 0, 0, 0, 1); #1;
        chk("load_no_match", {7'd0, ctl}, {7'd0, C_NONE});
        set_in(0, 0, 0, 0, 1, 1, 0, 0, 1); #1;
        chk("branch_only", {7'd0, ctl}, {7'd0, C_BRANCH});
        set_in(1, 5, 5, 0, 1, 1, 0, 0, 1); #1;
        chk("branch_over_load_use", {7'd0, ctl}, {7'd0, C_BRANCH});
        set_in(1, 5, 5, 0, 1, 0, 0, 0, 1); #1;
        chk("branch_not_taken", {7'd0, ctl}, {7'd0, C_LDUSE});
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 1); #1;
        chk("memop_ready", {7'd0, ctl}, {7'd0, C_NONE});
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("store_not_ready", {7'd0, ctl}, {7'd0, C_FREEZE});

        // Memory wait with a branch and load-use also pending
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        set_in(1, 5, 5, 0, 1, 1, 1, 0, 0); #1;
        chk("memwait_c1", {7'd0, ctl}, {7'd0, C_FREEZE});
        tick(1); #1;
        chk("memwait_c2", {7'd0, ctl}, {7'd0, C_FREEZE});
        tick(1); #1;
        chk("memwait_c3", {7'd0, ctl}, {7'd0, C_FREEZE});
        tick(1);
        dmem_ready = 1'b1; #1;
        chk("memwait_release", {7'd0, ctl}, {7'd0, C_BRANCH});
        tick(1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("memwait_back_run", {7'd0, ctl}, {7'd0, C_NONE});
`ifdef HAZ_PERF_CNT_EN
        chk("memwait_stall_cnt", stall_cnt, 16'd3);
`else
        chk("memwait_stall_cnt", stall_cnt, 16'd0);
`endif

        // Timeout: 300 cycles with memory not ready
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick(256); #1;
        chk("timeout_before", {15'd0, mem_timeout}, 16'd0);
        tick(1); #1;
        chk("timeout_set", {15'd0, mem_timeout}, 16'd1);
        chk("timeout_still_wait", {7'd0, ctl}, {7'd0, C_FREEZE});
        tick(43);
        dmem_ready = 1'b1; #1;
        chk("timeout_release", {7'd0, ctl}, {7'd0, C_NONE});
`ifdef HAZ_PERF_CNT_EN
        chk("timeout_stall_cnt", stall_cnt, 16'd300);
`endif
        tick(3); #1;
        chk("timeout_sticky", {15'd0, mem_timeout}, 16'd1);

        // Reset while in MEM_WAIT
        dmem_ready = 1'b0;
        tick(1);
        exmem_memread = 1'b0; #1;
        chk("midwait_frozen", {7'd0, ctl}, {7'd0, C_FREEZE});
        rst = 1'b0; #1;
        chk("midwait_rst_ctl", {7'd0, ctl}, {7'd0, C_NONE});
        chk("midwait_rst_timeout", {15'd0, mem_timeout}, 16'd0);
        chk("midwait_rst_stall_cnt", stall_cnt, 16'd0);
        tick(1);
        rst = 1'b1;
        tick(1); #1;
        chk("midwait_after_rst", {7'd0, ctl}, {7'd0, C_NONE});

`ifdef HAZ_PERF_CNT_EN
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick(65534); #1;
        chk("stall_cnt_fffe", stall_cnt, 16'hFFFE);
        tick(6); #1;
        chk("stall_cnt_sat", stall_cnt, 16'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, reset: asynchronous, active-low (0 = reset).
REQ-003 SHALL have port idex_memread, input, 1, load instruction in the EX stage.
REQ-004 SHALL have port idex_rt, input, 5, destination register of the load in EX.
REQ-005 SHALL have ports ifid_rs and ifid_rt, input, 5 each, source registers of the instruction in ID.
REQ-006 SHALL have ports exmem_branch and exmem_zero, input, 1 each, branch and ALU-zero flags in the MEM stage.
REQ-007 SHALL have ports exmem_memread and exmem_memwrite, input, 1 each, memory operation in the MEM stage.
REQ-008 SHALL have port dmem_ready, input, 1, data memory has completed the current access.
REQ-009 SHALL have ports pc_en, ifid_en, idex_en, exmem_en and memwb_en, output, 1 each, stage-register load enables.
REQ-010 SHALL have ports ifid_flush, idex_flush, exmem_flush and memwb_flush, output, 1 each, insert a bubble (all control bits zero) at the next edge.
REQ-011 SHALL have port mem_timeout, output, 1, sticky error flag for a memory access that does not complete.
REQ-012 SHALL have port stall_cnt, output, 16, count of cycles in which pc_en = 0.

Function
REQ-013 SHALL implement an FSM with two states: RUN and MEM_WAIT.
REQ-014 SHALL define memop = exmem_memread | exmem_memwrite.
REQ-015 SHALL define memstall = memop & ~dmem_ready.
REQ-016 SHALL compute all enable and flush outputs combinationally from the current state and inputs, so they take effect at the next edge with zero cycles of added latency.
REQ-017 In RUN with memstall = 1: all enables SHALL be 0, memwb_flush SHALL be 1, other flushes SHALL be 0, and the next state SHALL be MEM_WAIT.
REQ-018 In MEM_WAIT: all enables SHALL be 0 and memwb_flush SHALL be 1 while dmem_ready = 0; on dmem_ready = 1 the outputs SHALL equal RUN outputs with memstall = 0 and the next state SHALL be RUN.
REQ-019 The branch flush (exmem_branch & exmem_zero, no memstall) SHALL drive all enables to 1 and ifid_flush, idex_flush and exmem_flush to 1.
REQ-020 Load-use is idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt); with no memstall and no branch flush it SHALL drive pc_en = 0, ifid_en = 0, idex_flush = 1, and all other enables to 1.
REQ-021 Priority SHALL be memstall, then branch flush, then load-use; a branch flush SHALL suppress load-use because ID is flushed.
REQ-022 With no hazard present, all enables SHALL be 1 and all flushes SHALL be 0.
REQ-023 An 8-bit wait counter SHALL clear on entry to MEM_WAIT and increment each cycle spent in MEM_WAIT.
REQ-024 When the wait counter reaches 255, mem_timeout SHALL be set and SHALL stay set until reset; the FSM SHALL keep waiting.
REQ-025 stall_cnt SHALL increment by 1 on each edge at which pc_en = 0, and SHALL saturate at 16'hFFFF with no wrap.

Reset
REQ-026 On rst = 0, the FSM state SHALL be RUN and the wait counter, stall_cnt and mem_timeout SHALL all be 0, asynchronously.
REQ-027 During reset, outputs SHALL reflect the RUN state with current inputs; a reset asserted mid-MEM_WAIT SHALL abandon the wait.
REQ-028 State SHALL update on the first rising clk edge after rst deasserts.

Configuration
REQ-029 Macro HAZ_PERF_CNT_EN defined: stall_cnt SHALL be implemented per REQ-025.
REQ-030 Macro HAZ_PERF_CNT_EN undefined: stall_cnt SHALL be constant 0 with no counter flops; all other behaviour SHALL be unchanged.

Verification
REQ-031 Load-use: idex_memread = 1, idex_rt = 5, ifid_rs = 5 -> pc_en = 0, ifid_en = 0, idex_flush = 1; repeat with idex_rt = 0 -> no stall.
REQ-032 Branch: exmem_branch = 1, exmem_zero = 1, load-use also true -> ifid_flush, idex_flush and exmem_flush = 1, pc_en = 1.
REQ-033 Memory wait: exmem_memread = 1, dmem_ready = 0 for 3 cycles then 1 -> 3 frozen cycles plus 1 advance cycle, then state RUN; stall_cnt = 3.
REQ-034 Timeout: dmem_ready held at 0 for 300 cycles -> mem_timeout rises after 256 MEM_WAIT cycles and stays set after dmem_ready = 1.
REQ-035 Reset mid-wait: rst = 0 during MEM_WAIT -> state RUN, stall_cnt = 0, mem_timeout = 0 immediately, before any clock edge.
REQ-036 Saturation (HAZ_PERF_CNT_EN defined): 65540 stall cycles -> stall_cnt = 16'hFFFF.
